// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: accepts one command (mode, step count, rate divider) and steps LED once per divided tick.
// Latency: first step div+1 cycles after accept; DONE pulses the cycle after the last step. CMD_READY only in IDLE.
module led_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_MODE,
    input  logic [CNT_W-1:0] CMD_COUNT,
    input  logic [DIV_W-1:0] CMD_DIV,
    input  logic             ABORT,
    output logic [WIDTH-1:0] LED,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] LED_ONE = WIDTH'(1);

    state_t           state, state_nxt;
    logic [1:0]       mode_q, mode_nxt;
    logic [CNT_W-1:0] steps_left, steps_nxt;
    logic [DIV_W-1:0] div_q, div_nxt;
    logic [DIV_W-1:0] prescaler, prescaler_nxt;
    logic [WIDTH-1:0] led_q, led_nxt;
    logic [WIDTH-1:0] step_val;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            mode_q     <= 2'd0;
            steps_left <= '0;
            div_q      <= '0;
            prescaler  <= '0;
            led_q      <= '0;
        end else begin
            state      <= state_nxt;
            mode_q     <= mode_nxt;
            steps_left <= steps_nxt;
            div_q      <= div_nxt;
            prescaler  <= prescaler_nxt;
            led_q      <= led_nxt;
        end
    end

    // Next LED value for the latched mode; all arithmetic wraps modulo 2^WIDTH.
    always_comb begin
        step_val = led_q;
        case (mode_q)
            2'd0:    step_val = led_q + LED_ONE;
            2'd1:    step_val = led_q - LED_ONE;
            2'd2:    step_val = (led_q == '0) ? LED_ONE : {led_q[WIDTH-2:0], led_q[WIDTH-1]};
            default: step_val = ~led_q;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        mode_nxt      = mode_q;
        steps_nxt     = steps_left;
        div_nxt       = div_q;
        prescaler_nxt = prescaler;
        led_nxt       = led_q;
        case (state)
            S_IDLE: begin
                if (CMD_VALID) begin
                    mode_nxt      = CMD_MODE;
                    steps_nxt     = CMD_COUNT;
                    div_nxt       = CMD_DIV;
                    prescaler_nxt = '0;
                    state_nxt     = (CMD_COUNT != '0) ? S_RUN : S_FIN;
                end
            end
            S_RUN: begin
                // Abort wins over a coinciding tick: no step, no DONE.
                if (ABORT) begin
                    state_nxt = S_IDLE;
                end else if (prescaler == div_q) begin
                    prescaler_nxt = '0;
                    led_nxt       = step_val;
                    steps_nxt     = steps_left - CNT_W'(1);
                    if (steps_left == CNT_W'(1)) begin
                        state_nxt = S_FIN;
                    end
                end else begin
                    prescaler_nxt = prescaler + DIV_W'(1);
                end
            end
            S_FIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign CMD_READY = (state == S_IDLE) && !RST;
    assign BUSY      = (state == S_RUN);
    assign DONE      = (state == S_FIN);
    assign LED       = led_q;

endmodule
